// File: rtl/tinyqv_arb_pkg.sv
// Shared state type, transfer size codes and beat-count helper for the
// TinyQV memory arbiter.
package tinyqv_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INSTR,
        INSTR_STOP,
        DATA,
        DATA_DONE
    } arb_state_e;

    localparam logic [1:0] SZ_8    = 2'b00;
    localparam logic [1:0] SZ_16   = 2'b01;
    localparam logic [1:0] SZ_32   = 2'b10;
    localparam logic [1:0] SZ_NONE = 2'b11;

    // Instruction fetches are issued as 4-beat bursts (len = beats-1).
    localparam logic [1:0] INSTR_LEN = 2'd3;

    function automatic logic [1:0] beats_for_size(input logic [1:0] size);
        return (size == SZ_32) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/tinyqv_beat_pack.sv
// Data-side beat handling: tracks the beat index, slices write data into
// 16-bit halves and assembles little-endian read data into a 32-bit word.
module tinyqv_beat_pack
    import tinyqv_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        beat,
    input  logic [1:0]  size,
    input  logic        is_write,
    input  logic [15:0] rdata,
    input  logic [31:0] wdata,
    output logic        last,
    output logic [15:0] wdata_half,
    output logic [31:0] data_in
);

    logic        beat_idx_q;
    logic [15:0] low_q;
    logic [31:0] data_in_q;
    logic [1:0]  last_idx;

    assign last_idx   = beats_for_size(size) - 2'd1;
    assign last       = beat && ({1'b0, beat_idx_q} == last_idx);
    assign wdata_half = beat_idx_q ? wdata[31:16] : wdata[15:0];
    assign data_in    = data_in_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_idx_q <= 1'b0;
            low_q      <= 16'h0000;
            data_in_q  <= 32'h0000_0000;
        end else begin
            if (clear) begin
                beat_idx_q <= 1'b0;
            end else if (beat) begin
                beat_idx_q <= ~beat_idx_q;
            end
            // data_in only moves when a read completes, so writes leave it intact.
            if (beat && !is_write) begin
                if (!beat_idx_q) begin
                    low_q <= rdata;
                end
                if (last) begin
                    case (size)
                        SZ_8:    data_in_q <= {24'h00_0000, rdata[7:0]};
                        SZ_16:   data_in_q <= {16'h0000, rdata};
                        default: data_in_q <= {rdata, low_q};
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/tinyqv_mem_arbiter.sv
// Arbitrates the TinyQV instruction fetch stream and data accesses onto one
// 16-bit memory port. Optional fetch guard: define TINYQV_ARB_FETCH_GUARD_EN.
module tinyqv_mem_arbiter
    import tinyqv_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic [23:1] instr_addr,
    input  logic        instr_fetch_restart,
    input  logic        instr_fetch_stall,
    output logic        instr_fetch_started,
    output logic        instr_fetch_stopped,
    output logic [15:0] instr_data_in,
    output logic        instr_ready,

    input  logic [24:0] data_addr,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    input  logic        data_continue,
    input  logic [31:0] data_out,
    output logic [31:0] data_in,
    output logic        data_ready,

    output logic        mem_start,
    output logic        mem_is_write,
    output logic [1:0]  mem_len,
    output logic [24:0] mem_addr,
    output logic        mem_continue,
    output logic        mem_stop,
    output logic [15:0] mem_wdata,
    input  logic        mem_busy,
    input  logic        mem_beat,
    input  logic [15:0] mem_rdata
);

    arb_state_e  state_q, state_d;
    logic        mem_start_q, mem_start_d;
    logic        started_q, started_d;
    logic        mem_stop_q, mem_stop_d;
    logic        data_ready_q, data_ready_d;
    logic        mem_is_write_q;
    logic [1:0]  mem_len_q;
    logic [24:0] mem_addr_q;
    logic        mem_continue_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;

    logic        data_req, req_write;
    logic [1:0]  req_size;
    logic        launch_data, launch_instr;
    logic        guard_block, preempt;
    logic        data_beat, beat_last;

    // A write wins when both a read and a write are (illegally) requested.
    assign req_write = (data_write_n != SZ_NONE);
    assign data_req  = req_write || (data_read_n != SZ_NONE);
    assign req_size  = req_write ? data_write_n : data_read_n;

    assign instr_ready   = (state_q == INSTR) && mem_beat && !instr_fetch_stall;
    assign instr_data_in = mem_rdata;
    assign data_beat     = (state_q == DATA) && mem_beat;
    assign preempt       = (data_req && !guard_block) || !instr_fetch_restart;

`ifdef TINYQV_ARB_FETCH_GUARD_EN
    logic       guard_on_q;
    logic [1:0] guard_cnt_q;
    logic       guard_arm;
    logic       guard_release;

    // Let the resumed fetch deliver 4 beats before data may preempt it again.
    assign guard_arm     = launch_instr && (state_q == DATA_DONE);
    assign guard_release = instr_ready && (guard_cnt_q == 2'd3);
    assign guard_block   = guard_on_q && !guard_release;

    always_ff @(posedge clk) begin
        if (rst || mem_stop_d) begin
            guard_on_q  <= 1'b0;
            guard_cnt_q <= 2'd0;
        end else if (guard_arm) begin
            guard_on_q  <= 1'b1;
            guard_cnt_q <= 2'd0;
        end else if (guard_on_q && instr_ready) begin
            guard_cnt_q <= guard_cnt_q + 2'd1;
            if (guard_cnt_q == 2'd3) begin
                guard_on_q <= 1'b0;
            end
        end
    end
`else
    assign guard_block = 1'b0;
`endif

    always_comb begin
        state_d             = state_q;
        mem_start_d         = 1'b0;
        started_d           = 1'b0;
        mem_stop_d          = 1'b0;
        data_ready_d        = 1'b0;
        launch_data         = 1'b0;
        launch_instr        = 1'b0;
        instr_fetch_stopped = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_req) begin
                    launch_data = 1'b1;
                end else if (instr_fetch_restart) begin
                    launch_instr = 1'b1;
                end
            end
            INSTR: begin
                if (preempt) begin
                    mem_stop_d = 1'b1;
                    state_d    = INSTR_STOP;
                end
            end
            INSTR_STOP: begin
                if (!mem_busy) begin
                    instr_fetch_stopped = 1'b1;
                    state_d             = IDLE;
                end
            end
            DATA: begin
                if (beat_last) begin
                    data_ready_d = 1'b1;
                    state_d      = DATA_DONE;
                end
            end
            DATA_DONE: begin
                if (data_continue && data_req) begin
                    launch_data = 1'b1;
                end else if (!data_req) begin
                    if (instr_fetch_restart) begin
                        launch_instr = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (launch_data) begin
            state_d     = DATA;
            mem_start_d = 1'b1;
        end
        if (launch_instr) begin
            state_d     = INSTR;
            mem_start_d = 1'b1;
            started_d   = 1'b1;
        end
    end

    // Reset abandons any transaction without mem_stop: the controller shares rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            mem_start_q    <= 1'b0;
            started_q      <= 1'b0;
            mem_stop_q     <= 1'b0;
            data_ready_q   <= 1'b0;
            mem_is_write_q <= 1'b0;
            mem_len_q      <= 2'd0;
            mem_addr_q     <= 25'd0;
            mem_continue_q <= 1'b0;
            size_q         <= SZ_NONE;
            wdata_q        <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            mem_start_q  <= mem_start_d;
            started_q    <= started_d;
            mem_stop_q   <= mem_stop_d;
            data_ready_q <= data_ready_d;
            if (launch_data) begin
                mem_is_write_q <= req_write;
                mem_len_q      <= beats_for_size(req_size) - 2'd1;
                mem_addr_q     <= data_addr;
                mem_continue_q <= data_continue;
                size_q         <= req_size;
                wdata_q        <= data_out;
            end else if (launch_instr) begin
                mem_is_write_q <= 1'b0;
                mem_len_q      <= INSTR_LEN;
                mem_addr_q     <= {1'b0, instr_addr, 1'b0};
                mem_continue_q <= 1'b0;
            end
        end
    end

    tinyqv_beat_pack u_beat_pack (
        .clk        (clk),
        .rst        (rst),
        .clear      (launch_data),
        .beat       (data_beat),
        .size       (size_q),
        .is_write   (mem_is_write_q),
        .rdata      (mem_rdata),
        .wdata      (wdata_q),
        .last       (beat_last),
        .wdata_half (mem_wdata),
        .data_in    (data_in)
    );

    assign mem_start           = mem_start_q;
    assign instr_fetch_started = started_q;
    assign mem_stop            = mem_stop_q;
    assign data_ready          = data_ready_q;
    assign mem_is_write        = mem_is_write_q;
    assign mem_len             = mem_len_q;
    assign mem_addr            = mem_addr_q;
    assign mem_continue        = mem_continue_q;

endmodule

// File: tb/tb_tinyqv_mem_arbiter.sv
// Directed self-checking bench for tinyqv_mem_arbiter; inputs change at the
// falling edge and outputs are sampled 1 time unit later.
module tb_tinyqv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:1] instr_addr;
    logic        instr_fetch_restart, instr_fetch_stall;
    logic        instr_fetch_started, instr_fetch_stopped, instr_ready;
    logic [15:0] instr_data_in;
    logic [24:0] data_addr;
    logic [1:0]  data_write_n, data_read_n;
    logic        data_continue, data_ready;
    logic [31:0] data_out, data_in;
    logic        mem_start, mem_is_write, mem_continue, mem_stop;
    logic [1:0]  mem_len;
    logic [24:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_busy, mem_beat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tinyqv_mem_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .instr_addr          (instr_addr),
        .instr_fetch_restart (instr_fetch_restart),
        .instr_fetch_stall   (instr_fetch_stall),
        .instr_fetch_started (instr_fetch_started),
        .instr_fetch_stopped (instr_fetch_stopped),
        .instr_data_in       (instr_data_in),
        .instr_ready         (instr_ready),
        .data_addr           (data_addr),
        .data_write_n        (data_write_n),
        .data_read_n         (data_read_n),
        .data_continue       (data_continue),
        .data_out            (data_out),
        .data_in             (data_in),
        .data_ready          (data_ready),
        .mem_start           (mem_start),
        .mem_is_write        (mem_is_write),
        .mem_len             (mem_len),
        .mem_addr            (mem_addr),
        .mem_continue        (mem_continue),
        .mem_stop            (mem_stop),
        .mem_wdata           (mem_wdata),
        .mem_busy            (mem_busy),
        .mem_beat            (mem_beat),
        .mem_rdata           (mem_rdata)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        instr_addr          = 23'd0;
        instr_fetch_restart = 1'b0;
        instr_fetch_stall   = 1'b0;
        data_addr           = 25'd0;
        data_write_n        = 2'b11;
        data_read_n         = 2'b11;
        data_continue       = 1'b0;
        data_out            = 32'd0;
        mem_busy            = 1'b0;
        mem_beat            = 1'b0;
        mem_rdata           = 16'd0;
    endtask

    task automatic apply_reset();
        cyc();
        rst = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        cyc();
        rst = 1'b1;
        idle_inputs();
        instr_fetch_restart = 1'b1;
        data_read_n = 2'b10;
        cyc(); cyc(); #1;
        total++; if (mem_start !== 1'b0) begin bad++; $display("FAIL rst_start: got %0b want 0", mem_start); end
        total++; if (mem_stop !== 1'b0) begin bad++; $display("FAIL rst_stop: got %0b want 0", mem_stop); end
        total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %0b want 0", data_ready); end
        total++; if (instr_fetch_started !== 1'b0) begin bad++; $display("FAIL rst_started: got %0b want 0", instr_fetch_started); end
        total++; if (mem_addr !== 25'd0 || mem_len !== 2'd0) begin bad++; $display("FAIL rst_attr: got addr=%0h len=%0d want 0/0", mem_addr, mem_len); end
        total++; if (mem_is_write !== 1'b0 || mem_continue !== 1'b0) begin bad++; $display("FAIL rst_flags: got wr=%0b cont=%0b want 0/0", mem_is_write, mem_continue); end
        total++; if (data_in !== 32'd0) begin bad++; $display("FAIL rst_data_in: got %0h want 0", data_in); end
        idle_inputs();
        rst = 1'b0;
        cyc(); #1;
        total++; if (mem_start !== 1'b0) begin bad++; $display("FAIL idle_no_start: got %0b want 0", mem_start); end
    endtask

    task automatic test_read32();
        cyc(); data_addr = 25'h000100; data_read_n = 2'b10; #1;
        total++; if (mem_start !== 1'b0) begin bad++; $display("FAIL rd_start_early: got %0b want 0", mem_start); end
        cyc(); data_addr = 25'h1FFFFFF; #1;
        total++; if (mem_start !== 1'b1 || mem_len !== 2'd1) begin bad++; $display("FAIL rd_start: got start=%0b len=%0d want 1/1", mem_start, mem_len); end
        total++; if (mem_addr !== 25'h000100 || mem_is_write !== 1'b0) begin bad++; $display("FAIL rd_attr: got addr=%0h wr=%0b want 100/0", mem_addr, mem_is_write); end
        cyc(); mem_beat = 1'b1; mem_rdata = 16'h1234; #1;
        total++; if (mem_start !== 1'b0 || data_ready !== 1'b0) begin bad++; $display("FAIL rd_beat0: got start=%0b ready=%0b want 0/0", mem_start, data_ready); end
        cyc(); mem_rdata = 16'hABCD; #1;
        total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL rd_beat1: got ready=%0b want 0", data_ready); end
        cyc(); mem_beat = 1'b0; data_read_n = 2'b11; #1;
        total++; if (data_ready !== 1'b1 || data_in !== 32'hABCD1234) begin bad++; $display("FAIL rd_done: got ready=%0b data=%0h want 1/abcd1234", data_ready, data_in); end
        cyc(); #1;
        total++; if (data_ready !== 1'b0 || data_in !== 32'hABCD1234) begin bad++; $display("FAIL rd_hold: got ready=%0b data=%0h want 0/abcd1234", data_ready, data_in); end
    endtask

    task automatic test_write32_continue();
        cyc(); data_addr = 25'h000300; data_write_n = 2'b10; data_out = 32'hCAFEF00D; data_continue = 1'b1; #1;
        cyc(); #1;
        total++; if (mem_start !== 1'b1 || mem_len !== 2'd1 || mem_is_write !== 1'b1) begin bad++; $display("FAIL wr_start: got start=%0b len=%0d wr=%0b want 1/1/1", mem_start, mem_len, mem_is_write); end
        total++; if (mem_continue !== 1'b1 || mem_wdata !== 16'hF00D) begin bad++; $display("FAIL wr_beat0: got cont=%0b wdata=%0h want 1/f00d", mem_continue, mem_wdata); end
        cyc(); mem_beat = 1'b1; #1;
        cyc(); #1;
        total++; if (mem_wdata !== 16'hCAFE) begin bad++; $display("FAIL wr_beat1: got %0h want cafe", mem_wdata); end
        cyc(); mem_beat = 1'b0; data_addr = 25'h000400; #1;
        total++; if (data_ready !== 1'b1 || data_in !== 32'd0) begin bad++; $display("FAIL wr_done: got ready=%0b data=%0h want 1/0", data_ready, data_in); end
        cyc(); #1;
        total++; if (mem_start !== 1'b1 || mem_addr !== 25'h000400 || data_ready !== 1'b0) begin bad++; $display("FAIL wr_cont: got start=%0b addr=%0h ready=%0b want 1/400/0", mem_start, mem_addr, data_ready); end
    endtask

    task automatic test_preempt_write();
        cyc(); instr_addr = 23'h000020; instr_fetch_restart = 1'b1; #1;
        cyc(); mem_busy = 1'b1; #1;
        total++; if (mem_start !== 1'b1 || instr_fetch_started !== 1'b1) begin bad++; $display("FAIL if_start: got start=%0b started=%0b want 1/1", mem_start, instr_fetch_started); end
        total++; if (mem_addr !== 25'h000040 || mem_len !== 2'd3 || mem_is_write !== 1'b0) begin bad++; $display("FAIL if_attr: got addr=%0h len=%0d wr=%0b want 40/3/0", mem_addr, mem_len, mem_is_write); end
        cyc(); mem_beat = 1'b1; mem_rdata = 16'h1111; #1;
        total++; if (instr_ready !== 1'b1 || instr_data_in !== 16'h1111) begin bad++; $display("FAIL if_beat: got rdy=%0b data=%0h want 1/1111", instr_ready, instr_data_in); end
        cyc(); mem_beat = 1'b0; data_write_n = 2'b00; data_out = 32'h00000055; data_addr = 25'h000200; #1;
        total++; if (mem_stop !== 1'b0) begin bad++; $display("FAIL pre_stop_early: got %0b want 0", mem_stop); end
        cyc(); #1;
        total++; if (mem_stop !== 1'b1 || instr_fetch_stopped !== 1'b0) begin bad++; $display("FAIL pre_stop: got stop=%0b stopped=%0b want 1/0", mem_stop, instr_fetch_stopped); end
        cyc(); mem_busy = 1'b0; #1;
        total++; if (mem_stop !== 1'b0 || instr_fetch_stopped !== 1'b1) begin bad++; $display("FAIL pre_stopped: got stop=%0b stopped=%0b want 0/1", mem_stop, instr_fetch_stopped); end
        cyc(); #1;
        total++; if (instr_fetch_stopped !== 1'b0 || mem_start !== 1'b0) begin bad++; $display("FAIL pre_idle: got stopped=%0b start=%0b want 0/0", instr_fetch_stopped, mem_start); end
        cyc(); mem_busy = 1'b1; #1;
        total++; if (mem_start !== 1'b1 || mem_is_write !== 1'b1 || mem_len !== 2'd0) begin bad++; $display("FAIL pw_start: got start=%0b wr=%0b len=%0d want 1/1/0", mem_start, mem_is_write, mem_len); end
        total++; if (mem_wdata !== 16'h0055 || mem_addr !== 25'h000200 || instr_fetch_started !== 1'b0) begin bad++; $display("FAIL pw_attr: got wdata=%0h addr=%0h started=%0b want 55/200/0", mem_wdata, mem_addr, instr_fetch_started); end
        cyc(); mem_beat = 1'b1; #1;
        cyc(); mem_beat = 1'b0; data_write_n = 2'b11; instr_addr = 23'h000030; #1;
        total++; if (data_ready !== 1'b1) begin bad++; $display("FAIL pw_done: got %0b want 1", data_ready); end
        cyc(); #1;
        total++; if (mem_start !== 1'b1 || instr_fetch_started !== 1'b1 || mem_addr !== 25'h000060) begin bad++; $display("FAIL if_resume: got start=%0b started=%0b addr=%0h want 1/1/60", mem_start, instr_fetch_started, mem_addr); end
    endtask

    task automatic test_simultaneous();
        cyc(); instr_addr = 23'h000100; instr_fetch_restart = 1'b1; data_read_n = 2'b01; data_addr = 25'h000010; #1;
        cyc(); #1;
        total++; if (mem_start !== 1'b1 || instr_fetch_started !== 1'b0 || mem_addr !== 25'h000010 || mem_len !== 2'd0) begin bad++; $display("FAIL sim_data_first: got start=%0b started=%0b addr=%0h len=%0d want 1/0/10/0", mem_start, instr_fetch_started, mem_addr, mem_len); end
        cyc(); mem_beat = 1'b1; mem_rdata = 16'hBEEF; #1;
        cyc(); mem_beat = 1'b0; data_read_n = 2'b11; #1;
        total++; if (data_ready !== 1'b1 || data_in !== 32'h0000BEEF || mem_start !== 1'b0) begin bad++; $display("FAIL sim_done: got ready=%0b data=%0h start=%0b want 1/beef/0", data_ready, data_in, mem_start); end
        cyc(); #1;
        total++; if (mem_start !== 1'b1 || instr_fetch_started !== 1'b1 || mem_addr !== 25'h000200) begin bad++; $display("FAIL sim_instr: got start=%0b started=%0b addr=%0h want 1/1/200", mem_start, instr_fetch_started, mem_addr); end
    endtask

    task automatic test_stall();
        int pulses = 0;
        cyc(); instr_addr = 23'h000008; instr_fetch_restart = 1'b1; #1;
        cyc(); mem_busy = 1'b1; #1;
        total++; if (mem_start !== 1'b1) begin bad++; $display("FAIL st_start: got %0b want 1", mem_start); end
        for (int i = 0; i < 4; i++) begin
            cyc(); instr_fetch_stall = 1'b1; mem_beat = 1'b1; mem_rdata = 16'h4000 + 16'(i); #1;
            if (instr_ready === 1'b1) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL st_no_ready: got %0d pulses want 0", pulses); end
        cyc(); instr_fetch_stall = 1'b0; mem_rdata = 16'h5A5A; #1;
        total++; if (instr_ready !== 1'b1 || instr_data_in !== 16'h5A5A) begin bad++; $display("FAIL st_resume: got rdy=%0b data=%0h want 1/5a5a", instr_ready, instr_data_in); end
    endtask

    task automatic test_guard();
        cyc(); instr_addr = 23'h000010; instr_fetch_restart = 1'b1; data_read_n = 2'b00; data_addr = 25'h000005; #1;
        cyc(); mem_busy = 1'b1; #1;
        cyc(); mem_beat = 1'b1; mem_rdata = 16'h77A5; #1;
        cyc(); mem_beat = 1'b0; data_read_n = 2'b11; #1;
        total++; if (data_ready !== 1'b1 || data_in !== 32'h000000A5) begin bad++; $display("FAIL gd_byte: got ready=%0b data=%0h want 1/a5", data_ready, data_in); end
        cyc(); #1;
        total++; if (mem_start !== 1'b1 || instr_fetch_started !== 1'b1) begin bad++; $display("FAIL gd_resume: got start=%0b started=%0b want 1/1", mem_start, instr_fetch_started); end
        cyc(); mem_beat = 1'b1; #1;
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL gd_beat1: got %0b want 1", instr_ready); end
        cyc(); mem_beat = 1'b0; data_read_n = 2'b01; #1;
`ifdef TINYQV_ARB_FETCH_GUARD_EN
        for (int i = 0; i < 3; i++) begin
            cyc(); mem_beat = 1'b1; #1;
            total++; if (mem_stop !== 1'b0) begin bad++; $display("FAIL gd_held%0d: got stop=%0b want 0", i, mem_stop); end
        end
        cyc(); mem_beat = 1'b0; #1;
        total++; if (mem_stop !== 1'b1) begin bad++; $display("FAIL gd_release: got stop=%0b want 1", mem_stop); end
`else
        cyc(); #1;
        total++; if (mem_stop !== 1'b1) begin bad++; $display("FAIL gd_preempt: got stop=%0b want 1", mem_stop); end
`endif
    endtask

    task automatic test_reset_mid();
        cyc(); data_read_n = 2'b01; data_addr = 25'h000008; #1;
        cyc(); mem_busy = 1'b1; #1;
        cyc(); mem_beat = 1'b1; mem_rdata = 16'h1357; #1;
        cyc(); mem_beat = 1'b0; data_read_n = 2'b11; #1;
        total++; if (data_in !== 32'h00001357) begin bad++; $display("FAIL rm_pre: got %0h want 1357", data_in); end
        cyc(); data_read_n = 2'b10; #1;
        cyc(); #1;
        cyc(); mem_beat = 1'b1; mem_rdata = 16'h1111; #1;
        cyc(); rst = 1'b1; mem_rdata = 16'h2222; data_read_n = 2'b11; #1;
        total++; if (mem_stop !== 1'b0) begin bad++; $display("FAIL rm_stop_in: got %0b want 0", mem_stop); end
        cyc(); rst = 1'b0; mem_beat = 1'b0; #1;
        total++; if (data_ready !== 1'b0 || mem_stop !== 1'b0 || mem_start !== 1'b0) begin bad++; $display("FAIL rm_after: got ready=%0b stop=%0b start=%0b want 0/0/0", data_ready, mem_stop, mem_start); end
        total++; if (data_in !== 32'd0 || mem_addr !== 25'd0 || mem_len !== 2'd0) begin bad++; $display("FAIL rm_clear: got data=%0h addr=%0h len=%0d want 0/0/0", data_in, mem_addr, mem_len); end
        cyc(); #1;
        total++; if (data_ready !== 1'b0 || mem_stop !== 1'b0) begin bad++; $display("FAIL rm_idle: got ready=%0b stop=%0b want 0/0", data_ready, mem_stop); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        apply_reset(); test_read32();
        apply_reset(); test_write32_continue();
        apply_reset(); test_preempt_write();
        apply_reset(); test_simultaneous();
        apply_reset(); test_stall();
        apply_reset(); test_guard();
        apply_reset(); test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tinyqv_mem_arbiter.md
TINYQV_MEM_ARBITER -- requirements
Module: tinyqv_mem_arbiter

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-002 SHALL have instr side: instr_addr in 23 ([23:1]); instr_fetch_restart in 1; instr_fetch_stall in 1; instr_fetch_started out 1; instr_fetch_stopped out 1; instr_data_in out 16; instr_ready out 1.
REQ-003 SHALL have data side: data_addr in 25; data_write_n in 2; data_read_n in 2; data_continue in 1; data_out in 32 (write data); data_in out 32; data_ready out 1. The size codes are 11 none, 00 8-bit, 01 16-bit, 10 32-bit.
REQ-004 SHALL have memory side: mem_start out 1; mem_is_write out 1; mem_len out 2 (beats-1); mem_addr out 25; mem_continue out 1; mem_stop out 1; mem_wdata out 16; mem_busy in 1; mem_beat in 1; mem_rdata in 16.

Function
REQ-005 SHALL use FSM states IDLE, INSTR, INSTR_STOP, DATA, DATA_DONE.
REQ-006 IDLE: a data request (data_write_n!=11 or data_read_n!=11) SHALL win over instruction; the arbiter SHALL pulse mem_start for one cycle with the data attributes and then go to DATA.
REQ-007 IDLE, with no data request and instr_fetch_restart=1: the arbiter SHALL pulse mem_start with mem_is_write=0, mem_addr={instr_addr,0} and mem_len=3, pulse instr_fetch_started, and go to INSTR.
REQ-008 INSTR, on each mem_beat: instr_data_in=mem_rdata and instr_ready=1 for that cycle. When instr_fetch_stall=1, mem_beat SHALL be ignored.
REQ-009 INSTR: a data request, or instr_fetch_restart falling to 0, SHALL pulse mem_stop and go to INSTR_STOP.
REQ-010 INSTR_STOP: on mem_busy=0 the arbiter SHALL pulse instr_fetch_stopped and return to IDLE the same cycle.
REQ-011 8/16-bit transfers SHALL be 1 beat. 32-bit SHALL be 2 beats, little-endian: beat0 is bits [15:0], beat1 is bits [31:16]. 8-bit reads SHALL zero-extend data_in[31:8]. mem_wdata SHALL present the beat's half of data_out.
REQ-012 DATA: when the final mem_beat arrives, the arbiter SHALL go to DATA_DONE and data_ready=1 for exactly one cycle in DATA_DONE. data_in SHALL hold until the next data read completes.
REQ-013 DATA_DONE: it SHALL go to IDLE when the request is released (size=11), or restart DATA immediately if data_continue=1 and a new request is present. mem_continue SHALL equal the latched data_continue.
REQ-014 Request attributes SHALL be latched at mem_start. Changes to data_* during DATA SHALL be ignored.
REQ-015 A data request and instr_fetch_restart asserted simultaneously in IDLE SHALL result in data first. The instruction fetch SHALL restart after DATA_DONE with no extra idle cycle if instr_fetch_restart is still 1.
REQ-016 Simultaneous read and write requests SHALL be illegal. If both are present, the write wins.

Reset
REQ-017 With rst=1: state=IDLE, all pulse outputs 0, mem_addr/mem_len/mem_is_write/mem_continue=0, data_in=0.
REQ-018 Reset mid-transaction SHALL abandon it. mem_stop SHALL NOT be issued, because the memory controller is reset by the same rst.

Configuration
REQ-019 Macro TINYQV_ARB_FETCH_GUARD_EN.
- When defined: after DATA_DONE->INSTR, a 2-bit guard counter SHALL block data preemption until 4 instruction beats have been delivered. The counter SHALL be cleared by a stop or by reset.
- When undefined: data SHALL preempt INSTR immediately, and no counter SHALL exist.

Structure
REQ-020 A shared package tinyqv_arb_pkg SHALL hold the state enum, the size-code constants (SZ_NONE, SZ_8, SZ_16, SZ_32), and the function beats_for_size.
REQ-021 One sub-module is natural: tinyqv_beat_pack, the 16-to-32 read assembler and the 32-to-16 write slicer with a beat index.

Verification
REQ-022 Idle, data_read_n=10, addr 0x000100, beats 0x1234 then 0xABCD -> mem_start with mem_len=1; data_in=0xABCD1234; one data_ready pulse.
REQ-023 INSTR streaming at 0x000040, data_write_n=00 with data_out=0x55 -> mem_stop; instr_fetch_stopped after mem_busy=0; write mem_wdata=0x0055, len 0; instr restart at the current instr_addr.
REQ-024 Simultaneous restart and data_read_n=01 in IDLE -> data transaction first; instr mem_start the cycle after DATA_DONE.
REQ-025 Instruction beats with instr_fetch_stall=1 -> no instr_ready pulses.
REQ-026 With the guard macro defined: a data request 1 beat after instr resume -> no mem_stop until the 4th beat. With it undefined -> mem_stop on the next cycle.
REQ-027 rst asserted in DATA mid-beat -> next cycle state IDLE, data_ready=0, no mem_stop.
